match_turn_scheduler: RTL

MATCH_TURN_SCHEDULER -- requirements
Module: match_turn_scheduler

---
 rtl/match_turn_scheduler.sv | 134 +++++++++++++
 1 files changed

// File: rtl/match_turn_scheduler.sv
// Turn scheduler for a 4x4 memory-match game: two-card reveal, compare, hold,
// per-turn countdown, scoring for two players and game-over handling.
module match_turn_scheduler #(
    parameter int TURN_SECS   = 15,
    parameter int HOLD_CYCLES = 25000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        select,
    input  logic [1:0]  cur_x,
    input  logic [1:0]  cur_y,
    input  logic        tick_1s,
    output logic [3:0]  rd_addr,
    input  logic [2:0]  rd_data,
    output logic [31:0] cell_status,
    output logic        player,
    output logic [3:0]  score_j1,
    output logic [3:0]  score_j2,
    output logic [4:0]  secs_left,
    output logic        pair_found,
    output logic        game_over
);
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [2:0] {WAIT1, READ1, WAIT2, READ2, CMP, HOLD, OVER} state_t;

    state_t          state, state_nxt;
    logic [HW-1:0]   hold_cnt;
    logic [3:0]      first_addr;
    logic [2:0]      first_val, second_val;
    logic [1:0]      cur_st;
    logic            sel_hidden, timeout, vals_eq;
    logic [4:0]      pair_sum;

    assign cur_st     = cell_status[{cur_y, cur_x, 1'b0} +: 2];
    assign sel_hidden = select && (cur_st == 2'b00);
    // secs_left only reaches 0 through a timeout tick; that cycle runs the turn change
    assign timeout    = ((state == WAIT1) || (state == WAIT2)) && (secs_left == 5'd0);
    assign vals_eq    = (first_val == second_val);
    assign pair_sum   = {1'b0, score_j1} + {1'b0, score_j2} + 5'd1;
    assign game_over  = (state == OVER);

    always_comb begin
        state_nxt = state;
        case (state)
            WAIT1:   if (timeout) state_nxt = WAIT1;
                     else if (sel_hidden) state_nxt = READ1;
            READ1:   state_nxt = WAIT2;
            WAIT2:   if (timeout) state_nxt = WAIT1;
                     else if (sel_hidden) state_nxt = READ2;
            READ2:   state_nxt = CMP;
            CMP:     if (vals_eq) state_nxt = (pair_sum == 5'd8) ? OVER : WAIT1;
                     else state_nxt = HOLD;
            HOLD:    if (hold_cnt == '0) state_nxt = WAIT1;
            OVER:    if (select) state_nxt = WAIT1;
            default: state_nxt = WAIT1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= WAIT1;
            hold_cnt    <= '0;
            first_addr  <= '0;
            first_val   <= '0;
            second_val  <= '0;
            rd_addr     <= '0;
            cell_status <= '0;
            player      <= 1'b0;
            score_j1    <= '0;
            score_j2    <= '0;
            secs_left   <= 5'(TURN_SECS);
            pair_found  <= 1'b0;
        end else begin
            state      <= state_nxt;
            pair_found <= 1'b0;
            case (state)
                WAIT1, WAIT2: begin
                    if (timeout) begin
                        for (int i = 0; i < 16; i++)
                            if (cell_status[2*i +: 2] == 2'b01) cell_status[2*i +: 2] <= 2'b00;
                        player    <= ~player;
                        secs_left <= 5'(TURN_SECS);
                    end else if (sel_hidden) begin
                        rd_addr <= {cur_y, cur_x};
                    end else if (tick_1s) begin
                        secs_left <= secs_left - 5'd1;
                    end
                end
                READ1: begin
                    first_val  <= rd_data;
                    first_addr <= rd_addr;
                    cell_status[{rd_addr, 1'b0} +: 2] <= 2'b01;
                end
                READ2: begin
                    second_val <= rd_data;
                    cell_status[{rd_addr, 1'b0} +: 2] <= 2'b01;
                end
                CMP: begin
                    if (vals_eq) begin
                        cell_status[{first_addr, 1'b0} +: 2] <= 2'b10;
                        cell_status[{rd_addr, 1'b0} +: 2]    <= 2'b10;
                        if (player) score_j2 <= score_j2 + 4'd1;
                        else        score_j1 <= score_j1 + 4'd1;
                        pair_found <= 1'b1;
                        secs_left  <= 5'(TURN_SECS);
                    end else begin
                        hold_cnt <= HW'(HOLD_CYCLES - 1);
                    end
                end
                HOLD: begin
                    if (hold_cnt == '0) begin
                        cell_status[{first_addr, 1'b0} +: 2] <= 2'b00;
                        cell_status[{rd_addr, 1'b0} +: 2]    <= 2'b00;
                        player    <= ~player;
                        secs_left <= 5'(TURN_SECS);
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                OVER: begin
                    if (select) begin
                        cell_status <= '0;
                        score_j1    <= '0;
                        score_j2    <= '0;
                        player      <= 1'b0;
                        secs_left   <= 5'(TURN_SECS);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
